// File: rtl/ip2_test4_burst_capture.sv
// IP2 test4 sequencer: steps the DUT through reset_not, vin_test_trig_out and scan_load
// phases aligned to the free-running clk_counter. Then it captures N_CH DNN output lines
// into per-channel shift registers, repeating trigger/capture for up to burst_count bursts.
module ip2_test4_burst_capture #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned DEPTH   = 48,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned BURST_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        clk_counter,
    input  logic [CNT_W-1:0]        test_delay,
    input  logic [CNT_W-1:0]        test_trig_out_phase,
    input  logic [CNT_W-1:0]        scan_load_delay,
    input  logic                    scan_load_delay_disable,
    input  logic                    test_mask_reset_not,
    input  logic                    start_re,
    input  logic [BURST_W-1:0]      burst_count,
    input  logic [CNT_W-1:0]        capture_skip,
    input  logic [N_CH-1:0]         dnn_in,
    output logic [3:0]              state,
    output logic                    reset_not,
    output logic                    vin_test_trig_out,
    output logic                    scan_load,
    output logic                    busy,
    output logic                    status_done,
    output logic [BURST_W-1:0]      burst_idx,
    output logic                    capture_valid,
    output logic [N_CH*DEPTH-1:0]   dnn_capture
);

    localparam int unsigned CAP_W = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        StIdle          = 4'd0,
        StDelayTest     = 4'd1,
        StResetNot      = 4'd2,
        StTrigHi1       = 4'd3,
        StTrigHi2       = 4'd4,
        StDelayScanload = 4'd5,
        StScanload1     = 4'd6,
        StScanload2     = 4'd7,
        StNext          = 4'd8,
        StDone          = 4'd9
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        dly_cnt_q, dly_cnt_d;
    logic [CNT_W-1:0]        skip_cnt_q, skip_cnt_d;
    logic [CAP_W-1:0]        cap_cnt_q, cap_cnt_d;
    logic [BURST_W-1:0]      burst_idx_q, burst_idx_d;
    logic [N_CH*DEPTH-1:0]   capture_q, capture_d;
    logic                    reset_not_q, reset_not_d;
    logic                    scan_load_q, scan_load_d;
    logic                    trig_q, trig_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;

    logic                    tick;
    logic                    trig_phase;
    logic                    in_window;
    logic                    last_burst;
    logic                    dly_reached;
    logic [BURST_W:0]        n_bursts;
    logic [DEPTH-1:0]        lane;

    assign tick       = (clk_counter == test_delay);
    assign trig_phase = (clk_counter == test_trig_out_phase);

    // With the scan_load phases skipped, the second trigger-high period doubles as capture window
    assign in_window = scan_load_delay_disable ? (state_q == StTrigHi2)
                                               : (state_q == StScanload2);

    // A burst count of zero still runs one burst
    assign n_bursts   = (burst_count == '0) ? (BURST_W + 1)'(1) : {1'b0, burst_count};
    assign last_burst = (({1'b0, burst_idx_q} + 1'b1) >= n_bursts);

    // dly_cnt_q counts completed ticks; the current tick is the (dly_cnt_q+1)-th
    assign dly_reached = (({1'b0, dly_cnt_q} + 1'b1) >= {1'b0, scan_load_delay});

    // Next-state logic: tick-aligned phase sequencing, burst looping, enable override
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:          if (start_re) state_d = StDelayTest;
            StDelayTest:     if (tick) state_d = StResetNot;
            StResetNot:      if (tick) state_d = StTrigHi1;
            StTrigHi1:       if (tick) state_d = StTrigHi2;
            StTrigHi2: begin
                if (tick) begin
                    if (scan_load_delay_disable)   state_d = StNext;
                    else if (scan_load_delay == '0) state_d = StScanload1;
                    else                           state_d = StDelayScanload;
                end
            end
            StDelayScanload: if (tick && dly_reached) state_d = StScanload1;
            StScanload1:     if (tick) state_d = StScanload2;
            StScanload2:     if (tick) state_d = StNext;
            StNext:          state_d = last_burst ? StDone : StTrigHi1;
            StDone:          state_d = StIdle;
            default:         state_d = StIdle;
        endcase
        if (!enable) state_d = StIdle;
    end

    // Datapath next-state: counters, capture shift registers and registered DUT-pin outputs
    always_comb begin
        dly_cnt_d   = dly_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        burst_idx_d = burst_idx_q;
        capture_d   = capture_q;
        scan_load_d = scan_load_q;
        trig_d      = trig_q;
        done_d      = done_q;
        lane        = '0;

        if (state_q == StDelayScanload) begin
            if (tick) dly_cnt_d = dly_cnt_q + 1'b1;
        end else begin
            dly_cnt_d = '0;
        end

        // Discard capture_skip samples, then shift in up to DEPTH samples and freeze
        if (in_window) begin
            if (skip_cnt_q < capture_skip) begin
                skip_cnt_d = skip_cnt_q + 1'b1;
            end else if (cap_cnt_q < CAP_W'(DEPTH)) begin
                for (int c = 0; c < N_CH; c++) begin
                    lane = capture_q[c*DEPTH +: DEPTH];
                    lane = (lane << 1) | DEPTH'(dnn_in[c]);
                    capture_d[c*DEPTH +: DEPTH] = lane;
                end
                cap_cnt_d = cap_cnt_q + 1'b1;
            end
        end else begin
            skip_cnt_d = '0;
            cap_cnt_d  = '0;
        end

        if (state_q == StIdle && start_re) begin
            capture_d   = '0;
            burst_idx_d = '0;
            done_d      = 1'b0;
        end

        if (state_q == StNext && !last_burst) begin
            burst_idx_d = burst_idx_q + 1'b1;
            capture_d   = '0;
        end

        if (state_d == StDone) done_d = 1'b1;

        valid_d     = (state_d == StNext);
        reset_not_d = !(state_d == StResetNot && !test_mask_reset_not);

        // scan_load is decoded from the state being entered so it lines up with the transition
        case (state_d)
            StIdle, StDelayTest: scan_load_d = 1'b1;
            StResetNot:          scan_load_d = 1'b0;
            StTrigHi1: begin
                if (state_q != StTrigHi1) scan_load_d = scan_load_delay_disable;
            end
            StScanload1:         scan_load_d = 1'b1;
            default:             scan_load_d = scan_load_q;
        endcase

        if (state_q == StTrigHi1 && trig_phase) begin
            trig_d = 1'b1;
        end else if (state_q == StTrigHi2 && trig_phase) begin
            trig_d = 1'b0;
        end

        if (!enable) begin
            dly_cnt_d   = '0;
            skip_cnt_d  = '0;
            cap_cnt_d   = '0;
            burst_idx_d = '0;
            capture_d   = '0;
            reset_not_d = 1'b1;
            scan_load_d = 1'b1;
            trig_d      = 1'b0;
            done_d      = 1'b0;
            valid_d     = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_cnt_q   <= '0;
            skip_cnt_q  <= '0;
            cap_cnt_q   <= '0;
            burst_idx_q <= '0;
            capture_q   <= '0;
            reset_not_q <= 1'b1;
            scan_load_q <= 1'b1;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            dly_cnt_q   <= dly_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            burst_idx_q <= burst_idx_d;
            capture_q   <= capture_d;
            reset_not_q <= reset_not_d;
            scan_load_q <= scan_load_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
        end
    end

    assign state             = state_q;
    assign busy              = (state_q != StIdle);
    assign reset_not         = reset_not_q;
    assign scan_load         = scan_load_q;
    assign vin_test_trig_out = trig_q;
    assign status_done       = done_q;
    assign burst_idx         = burst_idx_q;
    assign capture_valid     = valid_q;
    assign dnn_capture       = capture_q;

endmodule

// File: tb/tb_ip2_test4_burst_capture.sv
// Scoreboard bench for ip2_test4_burst_capture: a timeline model predicts every capture
// strobe, scan_load rise and completion; a negedge monitor pops and compares.
module tb_ip2_test4_burst_capture;

    localparam int N_CH    = 2;
    localparam int DEPTH   = 48;
    localparam int CNT_W   = 6;
    localparam int BURST_W = 4;
    localparam int MEM     = 16384;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable = 1'b1;
    logic [CNT_W-1:0]      clk_counter;
    logic [CNT_W-1:0]      test_delay = '0;
    logic [CNT_W-1:0]      test_trig_out_phase = '0;
    logic [CNT_W-1:0]      scan_load_delay = '0;
    logic                  scan_load_delay_disable = 1'b1;
    logic                  test_mask_reset_not = 1'b0;
    logic                  start_re = 1'b0;
    logic [BURST_W-1:0]    burst_count = '0;
    logic [CNT_W-1:0]      capture_skip = '0;
    logic [N_CH-1:0]       dnn_in;
    logic [3:0]            state;
    logic                  reset_not, vin_test_trig_out, scan_load, busy, status_done;
    logic                  capture_valid;
    logic [BURST_W-1:0]    burst_idx;
    logic [N_CH*DEPTH-1:0] dnn_capture;

    int cyc = 0;
    logic [N_CH-1:0] dnn_mem [MEM];

    assign clk_counter = cyc[5:0];
    assign dnn_in      = dnn_mem[cyc % MEM];

    ip2_test4_burst_capture #(
        .N_CH(N_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .reset(rst), .enable(enable), .clk_counter(clk_counter),
        .test_delay(test_delay), .test_trig_out_phase(test_trig_out_phase),
        .scan_load_delay(scan_load_delay), .scan_load_delay_disable(scan_load_delay_disable),
        .test_mask_reset_not(test_mask_reset_not), .start_re(start_re),
        .burst_count(burst_count), .capture_skip(capture_skip), .dnn_in(dnn_in),
        .state(state), .reset_not(reset_not), .vin_test_trig_out(vin_test_trig_out),
        .scan_load(scan_load), .busy(busy), .status_done(status_done),
        .burst_idx(burst_idx), .capture_valid(capture_valid), .dnn_capture(dnn_capture)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                    cyc;
        int                    idx;
        logic [N_CH*DEPTH-1:0] cap;
    } exp_t;

    exp_t exp_q[$];
    int   exp_sl[$];
    int   exp_done[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   low_cnt = 0;
    int   trig_rise = 0;
    int   win0 = 0;
    logic sl_prev = 1'b1, done_prev = 1'b0, trig_prev = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int next_tick(input int c, input int d);
        int r = c;
        while ((r % 64) != d) r++;
        return r;
    endfunction

    // Expected capture: skip the first samples of the window, keep at most DEPTH, newest in LSB
    function automatic logic [N_CH*DEPTH-1:0] cap_model(input int ws, input int we, input int skip);
        logic [N_CH*DEPTH-1:0] r;
        logic [DEPTH-1:0]      v;
        logic [N_CH-1:0]       s;
        int                    n;
        r = '0;
        n = we - ws + 1 - skip;
        if (n < 0) n = 0;
        if (n > DEPTH) n = DEPTH;
        for (int ch = 0; ch < N_CH; ch++) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                s = dnn_mem[(ws + skip + i) % MEM];
                v = {v[DEPTH-2:0], s[ch]};
            end
            r[ch*DEPTH +: DEPTH] = v;
        end
        return r;
    endfunction

    // Timeline of one run from the cycle in which start_re is sampled
    task automatic predict(input int k0, input int d, input bit dis, input int sld,
                           input int nb, input int skip);
        int   t, h1s, h1e, h2s, h2e, s1s, s1e, ws, we, e;
        exp_t x;
        t   = next_tick(k0 + 1, d);
        t   = next_tick(t + 1, d);
        h1s = t + 1;
        for (int b = 0; b < nb; b++) begin
            h1e = next_tick(h1s, d);
            h2s = h1e + 1;
            h2e = next_tick(h2s, d);
            if (dis) begin
                ws = h2s;
                we = h2e;
                if (b == 0) exp_sl.push_back(h1s);
            end else begin
                e = h2e;
                for (int k = 0; k < sld; k++) e = next_tick(e + 1, d);
                s1s = e + 1;
                exp_sl.push_back(s1s);
                s1e = next_tick(s1s, d);
                ws  = s1e + 1;
                we  = next_tick(ws, d);
            end
            if (b == 0) win0 = ws;
            x.cyc = we + 1;
            x.idx = b;
            x.cap = cap_model(ws, we, skip);
            exp_q.push_back(x);
            h1s = we + 2;
        end
        exp_done.push_back(h1s);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or edge
    always @(negedge clk) begin
        if (rst) begin
            sl_prev   = scan_load;
            done_prev = status_done;
            trig_prev = vin_test_trig_out;
        end else begin
            if (!reset_not) low_cnt++;
            if (vin_test_trig_out && !trig_prev) trig_rise++;
            if (scan_load && !sl_prev) begin
                check("sl_rise_expected", 128'(exp_sl.size() > 0), 128'(1));
                if (exp_sl.size() > 0) check("sl_rise_cycle", 128'(cyc), 128'(exp_sl.pop_front()));
            end
            if (capture_valid) begin
                check("valid_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("valid_cycle", 128'(cyc), 128'(x.cyc));
                    check("burst_idx", 128'(burst_idx), 128'(x.idx));
                    check("dnn_capture", 128'(dnn_capture), 128'(x.cap));
                    check("trig_low_at_valid", 128'(vin_test_trig_out), 128'(0));
                end
            end
            if (status_done && !done_prev) begin
                check("done_expected", 128'(exp_done.size() > 0), 128'(1));
                if (exp_done.size() > 0) check("done_cycle", 128'(cyc), 128'(exp_done.pop_front()));
            end
            sl_prev   = scan_load;
            done_prev = status_done;
            trig_prev = vin_test_trig_out;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_busy"},          128'(busy),              128'(0));
        check({tag, "_reset_not"},     128'(reset_not),         128'(1));
        check({tag, "_scan_load"},     128'(scan_load),         128'(1));
        check({tag, "_trig"},          128'(vin_test_trig_out), 128'(0));
        check({tag, "_status_done"},   128'(status_done),       128'(0));
        check({tag, "_capture_valid"}, 128'(capture_valid),     128'(0));
        check({tag, "_burst_idx"},     128'(burst_idx),         128'(0));
        check({tag, "_dnn_capture"},   128'(dnn_capture),       128'(0));
    endtask

    task automatic fill(input int from, input int n, input int pat);
        for (int i = 0; i < n; i++) begin
            case (pat)
                1:       dnn_mem[(from + i) % MEM] = 2'b01;
                2:       dnn_mem[(from + i) % MEM] = ((from + i) % 2 == 1) ? 2'b11 : 2'b00;
                default: dnn_mem[(from + i) % MEM] = N_CH'($urandom);
            endcase
        end
    endtask

    // One complete run; mid_start re-pulses start_re while busy, abort_off resets inside window
    task automatic run_case(input string nm, input int d, input bit dis, input int sld,
                            input bit mask, input int bc, input int skip, input int pat,
                            input int mid_start, input int abort_off);
        int k0, nb;
        nb = (bc == 0) ? 1 : bc;
        @(posedge clk); #1;
        test_delay              = CNT_W'(d);
        test_trig_out_phase     = CNT_W'($urandom_range(63));
        scan_load_delay         = CNT_W'(sld);
        scan_load_delay_disable = dis;
        test_mask_reset_not     = mask;
        burst_count             = BURST_W'(bc);
        capture_skip            = CNT_W'(skip);
        fill(cyc, 6000, pat);
        @(posedge clk); #1;
        start_re  = 1'b1;
        k0        = cyc;
        low_cnt   = 0;
        trig_rise = 0;
        predict(k0, d, dis, sld, nb, skip);
        @(posedge clk); #1;
        start_re = 1'b0;
        for (int n = 0; n < 8000 && exp_done.size() > 0; n++) begin
            @(posedge clk); #1;
            start_re = (mid_start > 0 && cyc == k0 + mid_start);
            if (abort_off > 0 && cyc == win0 + abort_off) begin
                #1 rst = 1'b1;
                #1 check_reset({nm, "_abort"});
                exp_q.delete();
                exp_sl.delete();
                exp_done.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
        end
        start_re = 1'b0;
        check({nm, "_done_pending"}, 128'(exp_done.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_valid_left"}, 128'(exp_q.size()), 128'(0));
        check({nm, "_sl_left"},    128'(exp_sl.size()), 128'(0));
        check({nm, "_reset_not_low_cycles"}, 128'(low_cnt), 128'(mask ? 0 : 64));
        check({nm, "_trig_pulses"}, 128'(trig_rise), 128'(nb));
        check({nm, "_done_held"}, 128'(status_done), 128'(1));
        check({nm, "_idle"}, 128'(busy), 128'(0));
        exp_q.delete();
        exp_sl.delete();
        exp_done.delete();
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) dnn_mem[i] = N_CH'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        rst = 1'b0;

        run_case("t1_basic", 5, 1'b1, 0, 1'b0, 1, 0, 1, 0, 0);
        check("t1_ch0_ones", 128'(dnn_capture[DEPTH-1:0]), 128'(48'hFFFF_FFFF_FFFF));
        check("t1_ch1_zero", 128'(dnn_capture[2*DEPTH-1:DEPTH]), 128'(0));

        run_case("t2_sld3", 9, 1'b0, 3, 1'b0, 1, 0, 0, 0, 0);
        run_case("t3_burst4", 12, 1'b1, 0, 1'b0, 4, 0, 2, 0, 0);

        run_case("t4_skip20", 30, 1'b1, 0, 1'b0, 1, 20, 0, 0, 0);
        check("t4_ch0_top4", 128'(dnn_capture[DEPTH-1:DEPTH-4]), 128'(0));
        check("t4_ch1_top4", 128'(dnn_capture[2*DEPTH-1:2*DEPTH-4]), 128'(0));

        run_case("t5_mask", 40, 1'b0, 1, 1'b1, 2, 5, 0, 300, 0);

        run_case("t6_abort", 3, 1'b0, 0, 1'b0, 2, 0, 0, 0, 10);
        run_case("t6_after", 3, 1'b0, 2, 1'b0, 2, 7, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            run_case("rnd", $urandom_range(63), 1'($urandom), $urandom_range(2), 1'($urandom),
                     $urandom_range(4), $urandom_range(40), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
